// File: rtl/pipe_hazard_pkg.sv
// Shared types and constants for the hazard/forwarding controller.
// Slot records carry a fixed-width dest; narrower addresses are zero-extended.
package pipe_hazard_pkg;

  localparam int SLOT_RA_W = 8;
  localparam int FWD_NONE  = 0;
  localparam int SLOT_EXE  = 0;
  localparam int SLOT_MEM  = 1;

  typedef struct packed {
    logic                 valid;
    logic                 wb_en;
    logic                 mem_r_en;
    logic                 mem_w_en;
    logic [SLOT_RA_W-1:0] dest;
  } slot_t;

endpackage

// File: rtl/pipe_scoreboard.sv
// In-flight writer shift register: slot 0 is EXE, slot DEPTH-1 is WB.
// hold freezes every slot; kill or a missing insert loads an empty EXE slot.
module pipe_scoreboard
  import pipe_hazard_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              ins,
  input  logic              kill,
  input  slot_t             ins_slot,
  output slot_t [DEPTH-1:0] slots
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slots <= '0;
    end else if (!hold) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        slots[k] <= slots[k-1];
      end
      if (ins && !kill) begin
        slots[0] <= ins_slot;
      end else begin
        slots[0] <= '0;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard detection, forwarding selects and stall counting for the pipeline.
// Tracks in-flight writers itself so no per-stage destination ports are needed.
module pipe_hazard_ctrl
  import pipe_hazard_pkg::*;
#(
  parameter int RA_W   = 4,
  parameter int DEPTH  = 3,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid,
  input  logic                     id_src1_en,
  input  logic [RA_W-1:0]          id_src1,
  input  logic                     id_two_src,
  input  logic [RA_W-1:0]          id_src2,
  input  logic                     id_wb_en,
  input  logic                     id_mem_r_en,
  input  logic                     id_mem_w_en,
  input  logic [RA_W-1:0]          id_dest,
  input  logic                     flush,
  input  logic                     mem_ready,
  output logic                     stall,
  output logic                     bubble,
  output logic                     freeze_all,
  output logic [$clog2(DEPTH)-1:0] fwd_sel1,
  output logic [$clog2(DEPTH)-1:0] fwd_sel2,
  output logic [CNT_W-1:0]         stall_cnt
);

  localparam int SW = $clog2(DEPTH);

  slot_t [DEPTH-1:0] slots;
  slot_t             id_slot;
  logic              h1;
  logic              h2;
  logic              issue;
  logic              exe_src1_en;
  logic              exe_src2_en;
  logic [RA_W-1:0]   exe_src1;
  logic [RA_W-1:0]   exe_src2;
  logic              unused_bits;

  function automatic logic match(
    input logic            en,
    input logic [RA_W-1:0] src,
    input slot_t           s
  );
    return en & s.valid & s.wb_en &
           (s.dest == SLOT_RA_W'(src));
  endfunction

  always_comb begin
    id_slot          = '0;
    id_slot.valid    = 1'b1;
    id_slot.wb_en    = id_wb_en;
    id_slot.mem_r_en = id_mem_r_en;
    id_slot.mem_w_en = id_mem_w_en;
    id_slot.dest     = SLOT_RA_W'(id_dest);
  end

  // WB slot is never a hazard: the register file writes before it reads.
  always_comb begin
    h1 = 1'b0;
    h2 = 1'b0;
    if (FWD_EN != 0) begin
      h1 = match(id_src1_en, id_src1, slots[SLOT_EXE])
         & slots[SLOT_EXE].mem_r_en;
      h2 = match(id_two_src, id_src2, slots[SLOT_EXE])
         & slots[SLOT_EXE].mem_r_en;
    end else begin
      for (int k = 0; k < DEPTH - 1; k++) begin
        h1 = h1 | match(id_src1_en, id_src1, slots[k]);
        h2 = h2 | match(id_two_src, id_src2, slots[k]);
      end
    end
  end

  assign stall  = id_valid & (h1 | h2) & ~flush;
  assign bubble = stall;
  assign issue  = id_valid & ~stall & ~flush;

  assign freeze_all = slots[SLOT_MEM].valid
                    & (slots[SLOT_MEM].mem_r_en
                     | slots[SLOT_MEM].mem_w_en)
                    & ~mem_ready;

  pipe_scoreboard #(
    .DEPTH (DEPTH)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst),
    .hold     (freeze_all),
    .ins      (id_valid & ~stall),
    .kill     (flush),
    .ins_slot (id_slot),
    .slots    (slots)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exe_src1_en <= 1'b0;
      exe_src2_en <= 1'b0;
      exe_src1    <= '0;
      exe_src2    <= '0;
    end else if (!freeze_all) begin
      exe_src1_en <= issue & id_src1_en;
      exe_src2_en <= issue & id_two_src;
      if (issue) begin
        exe_src1 <= id_src1;
        exe_src2 <= id_src2;
      end
    end
  end

  // Scan oldest to youngest so the youngest producer wins.
  always_comb begin
    fwd_sel1 = SW'(FWD_NONE);
    fwd_sel2 = SW'(FWD_NONE);
    if (FWD_EN != 0) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        if (match(exe_src1_en, exe_src1, slots[k]))
          fwd_sel1 = SW'(k);
        if (match(exe_src2_en, exe_src2, slots[k]))
          fwd_sel2 = SW'(k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (stall && !freeze_all && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign unused_bits = ^{slots, exe_src1, exe_src2,
                         exe_src1_en, exe_src2_en};

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised hazard and forwarding controller for the ARM pipeline. It replaces the stall-only combinational hazard detector.
- Keeps an internal scoreboard of in-flight writers (EXE…WB), so it needs no per-stage destination ports.
- Issues IF/ID stall, ID/EX bubble and a memory-wait global freeze.
- When forwarding is enabled, it also generates operand forwarding selects for the instruction in EXE.

Parameters:
- RA_W, 4, register address width.
- DEPTH, 3, tracked stages after ID (slot 0 = EXE, slot DEPTH-1 = WB); legal 2..8.
- FWD_EN, 1, 1 = forwarding plus load-use stall only; 0 = stall-until-writeback.
- CNT_W, 32, stall performance counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a valid instruction.
- id_src1_en  in  1  ID reads Rn.
- id_src1  in  RA_W  Rn address.
- id_two_src  in  1  ID reads second source (Rm, or Rd for store).
- id_src2  in  RA_W  second source address.
- id_wb_en  in  1  ID instruction writes a register.
- id_mem_r_en  in  1  ID instruction is a load.
- id_mem_w_en  in  1  ID instruction is a store.
- id_dest  in  RA_W  ID destination.
- flush  in  1  branch taken in EXE.
- mem_ready  in  1  data memory handshake; 0 = access not complete.
- stall  out  1  freeze PC and IF/ID register.
- bubble  out  1  load NOP into ID/EX register.
- freeze_all  out  1  hold every pipeline register.
- fwd_sel1  out  $clog2(DEPTH)  EXE Rn source: 0 = register file, k = slot k.
- fwd_sel2  out  $clog2(DEPTH)  EXE second-source select, same encoding.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Reset (rst=0, asynchronous):
  - All slots invalid; EXE source registers cleared; stall_cnt=0.
  - All outputs 0.
- Slot contents:
  - Each slot holds {valid, wb_en, mem_r_en, mem_w_en, dest}.
  - Alongside slot 0 are registered exe_src1/exe_src2 with their enables.
- Match rule: match(src,k) = src_en & slot[k].valid & slot[k].wb_en & (slot[k].dest==src).
- Hazard, FWD_EN=0:
  - hazard = match of either ID source in any slot k in 0..DEPTH-2.
  - The WB slot is excluded: the register file writes before it reads.
- Hazard, FWD_EN=1:
  - hazard = match on slot 0 with slot[0].mem_r_en (load-use only).
- Stall and bubble:
  - stall = bubble = id_valid & hazard & ~flush.
  - Combinational, same cycle as the ID lookup.
  - flush overrides hazard.
- freeze_all:
  - freeze_all = slot[1].valid & (slot[1].mem_r_en | slot[1].mem_w_en) & ~mem_ready.
  - Slot 1 is MEM.
  - Combinational.
  - Consumers give it priority over stall and bubble.
- Advance (posedge, freeze_all=0):
  - slot[k] <= slot[k-1] for k ≥ 1.
  - slot[0] <= ID info when id_valid & ~stall & ~flush; otherwise invalid (bubble or flush).
  - EXE sources load under the same condition.
- freeze_all=1:
  - All slots and EXE sources hold.
  - flush is ignored that cycle; the branch source holds too.
- Forwarding, FWD_EN=1:
  - fwd_selN = smallest k in 1..DEPTH-1 with match(exe_srcN, k). The youngest producer wins.
  - 0 if there is no match.
  - Combinational from registered state.
- Forwarding, FWD_EN=0: fwd_sel1 = fwd_sel2 = 0 constantly.
- Source with no enable: never matches, never stalls, select = 0.
- Register 0 gets no special treatment; every register address is tracked.
- stall_cnt:
  - Increments on posedge when stall=1 & freeze_all=0.
  - Saturates at all-ones; no wrap.
- Reset mid-stall or mid-freeze: immediate return to the reset state; no pending hazard survives.

Decomposition:
- Package pipe_hazard_pkg holds:
  - the slot record type {valid, wb_en, mem_r_en, mem_w_en, dest};
  - FWD_NONE=0;
  - the slot index constants SLOT_EXE=0, SLOT_MEM=1.
- One sub-module, pipe_scoreboard: the DEPTH-entry shift register with hold/insert/kill controls. It exposes all slots flat.
- Match, priority and counter logic stay in pipe_hazard_ctrl.

Test Plan:
- Reset: drive stall traffic, then rst=0 mid-stall → stall, bubble, freeze_all, fwd_sel* = 0 at once; stall_cnt=0; first ID after release issues with no stall.
- Load-use (FWD_EN=1, DEPTH=3): LDR dest=1, then ADD src1=1 → stall=bubble=1 for exactly 1 cycle; two cycles later, with ADD in EXE, fwd_sel1=2; stall_cnt=1.
- ALU chain (FWD_EN=1): ADD dest=2, then SUB src1=2, src2=2 → no stall; next cycle fwd_sel1=fwd_sel2=1. With dest=4 in both MEM and WB → select=1.
- No forwarding (FWD_EN=0, DEPTH=3): ADD dest=3, then STR two_src=1, src2=3 → stall 2 cycles; released when the producer is in WB; stall_cnt=2; fwd_sel*=0.
- Memory wait: STR in MEM with mem_ready=0 for 3 cycles → freeze_all=1 for 3 cycles; slots unchanged; stall_cnt not incremented; resumes on mem_ready=1.
- Flush collision: load-use hazard and flush=1 in the same cycle → stall=bubble=0; slot 0 invalid next cycle; fwd_sel*=0 for that EXE slot.
